sprite_dma: RTL and testbench

//  Bus-master loader for the sprite register file: on a CPU start pulse, copies one

---
 rtl/sprite_dma_pkg.sv | 25 ++
 rtl/sprite_dma.sv | 127 ++++++++++++
 tb/tb_sprite_dma.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_dma_pkg.sv
// Shared definitions for the sprite record loader: record layout and FSM state encodings.
// The sprite unit and the CPU register decode import the same package, so the
// register indices and state codes stay consistent across all three blocks.
package sprite_dma_pkg;

   // One sprite record: 8 bitmap rows followed by the X and Y position bytes.
   localparam int DEF_SPRITE_BYTES = 10;
   localparam int SPR_ROW_LAST     = 7;
   localparam int SPR_X_IDX        = 8;
   localparam int SPR_Y_IDX        = 9;

   // Default bus widths.
   localparam int DEF_MEM_AW       = 16;
   localparam int DEF_SPR_AW       = 4;

   // Loader FSM states (3-bit encoding shared with debug/decode logic).
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT_VS = 3'd1,
      ST_REQ     = 3'd2,
      ST_WRITE   = 3'd3,
      ST_DONE    = 3'd4
   } dma_state_e;

endpackage

// File: rtl/sprite_dma.sv
// Sprite record loader. On an accepted start pulse it copies one record from main
// memory into the sprite register file, one byte per read/write pair, and only
// while vsync is high so the sprite unit never displays a half-updated sprite.
//
// Memory handshake: mem_req rises with mem_addr valid and both stay unchanged
// until the cycle in which mem_ack is high; mem_rdata is taken in that same cycle
// and mem_req is low from the next cycle. A zero-wait memory may ack in the very
// cycle mem_req rises. abort overrides everything, including a same-cycle ack,
// whose data is then discarded.
//
// All outputs are registers, so spr_we/spr_addr/spr_di are settled well before the
// falling edge at which the sprite unit samples them.
module sprite_dma
   import sprite_dma_pkg::*;
#(
   parameter int SPRITE_BYTES = DEF_SPRITE_BYTES,
   parameter int MEM_AW       = DEF_MEM_AW,
   parameter int SPR_AW       = DEF_SPR_AW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [MEM_AW-1:0] src_base,
   input  logic              abort,
   input  logic              vsync,
   output logic              busy,
   output logic              done,
   output logic              mem_req,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [7:0]        mem_rdata,
   output logic              spr_we,
   output logic [SPR_AW-1:0] spr_addr,
   output logic [7:0]        spr_di,
   output dma_state_e        dbg_state
);

   localparam logic [SPR_AW-1:0] LAST_IDX = SPR_AW'(SPRITE_BYTES - 1);

   dma_state_e        state;
   logic [SPR_AW-1:0] idx;
   logic [MEM_AW-1:0] base;
   logic [SPR_AW-1:0] idx_next;

   assign idx_next  = idx + SPR_AW'(1);
   assign dbg_state = state;

   // Loader FSM with registered outputs; abort returns to IDLE from any state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         spr_we   <= 1'b0;
         spr_addr <= '0;
         spr_di   <= '0;
         idx      <= '0;
         base     <= '0;
      end else if (abort) begin
         // Drop the transfer without a done pulse; any acked byte is discarded.
         state   <= ST_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         mem_req <= 1'b0;
         spr_we  <= 1'b0;
      end else begin
         // Strobes are single-cycle unless a state below raises them again.
         spr_we <= 1'b0;
         done   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  base  <= src_base;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= ST_WAIT_VS;
               end
            end
            ST_WAIT_VS: begin
               if (vsync) begin
                  mem_req  <= 1'b1;
                  mem_addr <= base + MEM_AW'(idx);
                  state    <= ST_REQ;
               end
            end
            ST_REQ: begin
               // Once issued, a read always completes even if vsync falls.
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  spr_we   <= 1'b1;
                  spr_addr <= idx;
                  spr_di   <= mem_rdata;
                  state    <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (idx == LAST_IDX) begin
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  idx <= idx_next;
                  if (vsync) begin
                     mem_req  <= 1'b1;
                     mem_addr <= base + MEM_AW'(idx_next);
                     state    <= ST_REQ;
                  end else begin
                     state <= ST_WAIT_VS;
                  end
               end
            end
            ST_DONE: begin
               // done falls here (default above) together with busy.
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               mem_req <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_dma.sv
// Bench for the sprite record loader: directed scenarios plus randomized
// transfers, checked against a record-level model of what must be written.
module tb_sprite_dma;
   import sprite_dma_pkg::*;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [15:0] src_base = 16'h0;
   logic        abort = 1'b0;
   logic        vsync = 1'b0;
   logic        busy;
   logic        done;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic        spr_we;
   logic [3:0]  spr_addr;
   logic [7:0]  spr_di;
   logic [2:0]  dbg_state;

   always #5 clk = ~clk;

   sprite_dma dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .src_base  (src_base),
      .abort     (abort),
      .vsync     (vsync),
      .busy      (busy),
      .done      (done),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .spr_we    (spr_we),
      .spr_addr  (spr_addr),
      .spr_di    (spr_di),
      .dbg_state (dbg_state)
   );

   // ---------------- memory model ----------------
   logic [7:0] mem [0:65535];
   int         lat = 0;
   int         wait_cnt = 0;
   bit         vs_rand = 1'b0;

   assign mem_ack   = mem_req && (wait_cnt >= lat);
   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (!mem_req || mem_ack) wait_cnt <= 0;
      else                     wait_cnt <= wait_cnt + 1;
   end

   // ---------------- scoreboard ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [11:0] exp_q[$];
   logic [15:0] addr_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Record-level model: one record = bytes base+0..base+9 (address wraps at 16 bits),
   // written to sprite registers 0..9 in order.
   task automatic prep(input logic [15:0] b, input bit pattern);
      for (int k = 0; k < DEF_SPRITE_BYTES; k++) begin
         logic [15:0] a;
         a = b + 16'(k);
         mem[a] = pattern ? 8'(8'hA0 + k) : 8'($urandom);
         exp_q.push_back({4'(k), mem[a]});
         addr_q.push_back(a);
      end
   endtask

   task automatic flush();
      exp_q.delete();
      addr_q.delete();
   endtask

   logic [15:0] held_addr = 16'h0;
   bit          held = 1'b0;
   logic [11:0] wexp;
   logic [15:0] aexp;

   always @(negedge clk) begin
      if (reset) begin
         if (spr_we) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
               n_errors++;
               $error("FAIL spurious_write addr=%0h data=%0h expected no write", spr_addr, spr_di);
            end
            if (exp_q.size() != 0) begin
               wexp = exp_q.pop_front();
               check("spr_write", {spr_addr, spr_di}, wexp);
            end
         end
         if (mem_req && mem_ack) begin
            n_checks++;
            assert (addr_q.size() != 0) else begin
               n_errors++;
               $error("FAIL spurious_read addr=%0h expected no read", mem_addr);
            end
            if (addr_q.size() != 0) begin
               aexp = addr_q.pop_front();
               check("mem_addr_seq", mem_addr, aexp);
            end
         end
         if (mem_req && held) check("mem_addr_stable", mem_addr, held_addr);
         held      = mem_req && !mem_ack;
         held_addr = mem_addr;
      end else begin
         held = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_start(input logic [15:0] b);
      @(posedge clk); #1;
      src_base = b;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      check("busy_after_start", busy, 1);
   endtask

   // Counts cycles with the start cycle as cycle 0; returns when done is seen.
   task automatic wait_done(input int limit, output int cyc);
      cyc = 1;
      while (1) begin
         @(posedge clk); #1;
         cyc++;
         if (vs_rand) vsync = ($urandom_range(0, 3) != 0);
         if (done || cyc > limit) break;
      end
      check("done_seen", done, 1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"},     busy, 0);
      check({tag, "_done"},     done, 0);
      check({tag, "_mem_req"},  mem_req, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_spr_we"},   spr_we, 0);
      check({tag, "_spr_addr"}, spr_addr, 0);
      check({tag, "_spr_di"},   spr_di, 0);
      check({tag, "_state"},    dbg_state, ST_IDLE);
   endtask

   task automatic abort_at_byte6(input string tag, input int l);
      logic [15:0] b;
      int          t;
      int          bad;
      lat = l;
      b   = 16'($urandom);
      prep(b, 0);
      do_start(b);
      t = 0;
      while (!(mem_req && mem_addr == 16'(b + 16'd6)) && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      check({tag, "_reached_byte6"}, mem_req && (mem_addr == 16'(b + 16'd6)), 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check({tag, "_state"},   dbg_state, ST_IDLE);
      check({tag, "_busy"},    busy, 0);
      check({tag, "_mem_req"}, mem_req, 0);
      check({tag, "_spr_we"},  spr_we, 0);
      bad = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (spr_we || done || busy || mem_req) bad++;
      end
      check({tag, "_quiet"}, bad, 0);
      check({tag, "_bytes_left"}, exp_q.size(), 4);
      flush();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int          cyc;
      int          bad;
      int          t;
      logic [15:0] b;
      logic [15:0] b2;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      @(negedge clk) reset = 1'b1;

      // Basic record, zero-wait memory, vsync already high
      lat   = 0;
      vsync = 1'b1;
      prep(16'h1200, 1);
      do_start(16'h1200);
      wait_done(100, cyc);
      check("t1_cycles", cyc, 22);
      check("t1_bytes_left", exp_q.size(), 0);
      @(posedge clk); #1;
      check("t1_busy_low", busy, 0);
      check("t1_done_pulse", done, 0);

      // Wait for vsync, then pause mid-record and resume
      vsync = 1'b0;
      b = 16'($urandom);
      prep(b, 0);
      do_start(b);
      bad = 0;
      repeat (50) begin
         @(posedge clk); #1;
         if (mem_req || !busy) bad++;
      end
      check("t2_hold_no_vsync", bad, 0);
      vsync = 1'b1;
      @(posedge clk); #1;
      check("t2_req_on_vsync", mem_req, 1);
      t = 0;
      while (!(spr_we && spr_addr == 4'd4) && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      check("t2_saw_byte4", spr_we && (spr_addr == 4'd4), 1);
      vsync = 1'b0;
      bad = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (mem_req || spr_we || !busy) bad++;
      end
      check("t2_paused", bad, 0);
      vsync = 1'b1;
      wait_done(200, cyc);
      check("t2_bytes_left", exp_q.size(), 0);

      // Slow memory: ack after 3 wait cycles
      lat = 3;
      b = 16'($urandom);
      prep(b, 0);
      do_start(b);
      wait_done(300, cyc);
      check("t3_cycles", cyc, 52);
      check("t3_bytes_left", exp_q.size(), 0);

      // Address wrap at the top of memory
      lat = $urandom_range(0, 3);
      prep(16'hFFFC, 0);
      do_start(16'hFFFC);
      wait_done(300, cyc);
      check("t4_bytes_left", exp_q.size(), 0);
      check("t4_reads_left", addr_q.size(), 0);

      // Abort at byte 6: coincident with ack, then before ack
      abort_at_byte6("t5_abort_ack", 0);
      abort_at_byte6("t6_abort_req", 2);

      // Start while busy is ignored; start during DONE is ignored
      lat = $urandom_range(0, 3);
      b  = 16'($urandom);
      b2 = b + 16'h0100;
      prep(b, 0);
      do_start(b);
      repeat (5) @(posedge clk);
      #1;
      src_base = b2;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      wait_done(300, cyc);
      check("t7_bytes_left", exp_q.size(), 0);
      b = 16'($urandom);
      prep(b, 0);
      do_start(b);
      wait_done(300, cyc);
      src_base = b2;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      check("t7_done_start_busy", busy, 0);
      check("t7_done_start_state", dbg_state, ST_IDLE);
      check("t7b_bytes_left", exp_q.size(), 0);

      // Randomized records with random latency and toggling vsync
      vs_rand = 1'b1;
      for (int i = 0; i < 6; i++) begin
         lat = $urandom_range(0, 3);
         b   = 16'($urandom);
         prep(b, 0);
         do_start(b);
         wait_done(2000, cyc);
         check("t8_bytes_left", exp_q.size(), 0);
      end
      vs_rand = 1'b0;
      vsync   = 1'b1;

      // Asynchronous reset in the middle of a read
      lat = 6;
      b = 16'($urandom);
      prep(b, 0);
      do_start(b);
      t = 0;
      while (!mem_req && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      check("t9_in_req", mem_req, 1);
      #3;
      reset = 1'b0;
      #1;
      check_outputs_zero("t9_async_reset");
      flush();
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Normal operation after reset
      lat = 0;
      b = 16'($urandom);
      prep(b, 0);
      do_start(b);
      wait_done(100, cyc);
      check("t10_cycles", cyc, 22);
      check("t10_bytes_left", exp_q.size(), 0);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
